// File: rtl/heater_sequencer.sv
// Staggers heater enable changes one channel per step interval, auto-disables faulted channels,
// and runs the per-channel err_clear pulse handshake. Error to disable takes 3 cycles; there is no backpressure.
module heater_sequencer #(
  parameter int NCHAN = 32,
  parameter int NCLR  = 16,
  parameter int NCNT  = 8
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [NCHAN-1:0] enable_req,
  input  logic [15:0]      step_wait,
  input  logic [NCHAN-1:0] fault_clear,
  input  logic [NCHAN-1:0] heater_error,
  output logic [NCHAN-1:0] heater_enable,
  output logic [NCHAN-1:0] heater_err_clear,
  output logic [NCHAN-1:0] fault_sticky,
  output logic [NCNT-1:0]  fault_count,
  output logic             busy,
  output logic             clear_fail
);

  localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int PW = $clog2(NCHAN + 1);
  localparam int SW = ((NCNT > PW) ? NCNT : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << NCNT) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [15:0]      timer, timer_nxt, step_load;
  logic [IW-1:0]    ch, ch_nxt;
  logic [NCHAN-1:0] err_meta, err_s;
  logic [NCHAN-1:0] clear_pending, clr_pend_nxt;
  logic [NCHAN-1:0] en_nxt, errclr_nxt, sticky_nxt;
  logic [NCHAN-1:0] fault_now, pend_on, pend_off;
  logic [PW-1:0]    fault_pop;
  logic [SW-1:0]    cnt_sum;
  logic [NCNT-1:0]  cnt_nxt;
  logic             fail_nxt;

  function automatic logic [IW-1:0] lowest(input logic [NCHAN-1:0] v);
    lowest = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (v[i]) lowest = IW'(i);
    end
  endfunction

  assign fault_now = err_s & heater_enable;
  assign pend_on   = enable_req & ~heater_enable & ~fault_sticky;
  assign pend_off  = ~enable_req & heater_enable;
  assign step_load = (step_wait == 16'd0) ? 16'd0 : step_wait - 16'd1;

  // Gated by reset so the flag reads 0 while reset is held, even with requests pending.
  assign busy = axi_aresetn & ((state != IDLE) | (|clear_pending) | (|pend_on) | (|pend_off));

  always_comb begin
    fault_pop = '0;
    for (int i = 0; i < NCHAN; i++) begin
      fault_pop = fault_pop + PW'(fault_now[i]);
    end
    cnt_sum = SW'(fault_count) + SW'(fault_pop);
    cnt_nxt = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[NCNT-1:0];
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    ch_nxt       = ch;
    en_nxt       = heater_enable;
    errclr_nxt   = heater_err_clear;
    sticky_nxt   = fault_sticky;
    clr_pend_nxt = clear_pending | (fault_clear & fault_sticky);
    fail_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (|clear_pending) begin
          ch_nxt             = lowest(clear_pending);
          errclr_nxt         = '0;
          errclr_nxt[ch_nxt] = 1'b1;
          timer_nxt          = 16'(NCLR - 1);
          state_nxt          = CLEAR;
        end else if (|pend_off) begin
          ch_nxt         = lowest(pend_off);
          en_nxt[ch_nxt] = 1'b0;
          timer_nxt      = step_load;
          state_nxt      = SETTLE;
        end else if (|pend_on) begin
          ch_nxt         = lowest(pend_on);
          en_nxt[ch_nxt] = 1'b1;
          timer_nxt      = step_load;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == 16'd0) state_nxt = IDLE;
        else timer_nxt = timer - 16'd1;
      end
      CLEAR: begin
        if (timer == 16'd0) begin
          errclr_nxt[ch]   = 1'b0;
          clr_pend_nxt[ch] = 1'b0;
          if (err_s[ch]) fail_nxt = 1'b1;
          else sticky_nxt[ch] = 1'b0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A fault on a bit wins over a sequencer enable of the same bit.
    en_nxt     = en_nxt & ~fault_now;
    sticky_nxt = sticky_nxt | fault_now;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state            <= IDLE;
      timer            <= '0;
      ch               <= '0;
      err_meta         <= '0;
      err_s            <= '0;
      clear_pending    <= '0;
      heater_enable    <= '0;
      heater_err_clear <= '0;
      fault_sticky     <= '0;
      fault_count      <= '0;
      clear_fail       <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      ch               <= ch_nxt;
      err_meta         <= heater_error;
      err_s            <= err_meta;
      clear_pending    <= clr_pend_nxt;
      heater_enable    <= en_nxt;
      heater_err_clear <= errclr_nxt;
      fault_sticky     <= sticky_nxt;
      fault_count      <= cnt_nxt;
      clear_fail       <= fail_nxt;
    end
  end

endmodule
